// File: rtl/clock_period_monitor.sv
// Oversamples an asynchronous clock with the sampling clock and reports the high,
// low and total period of every complete cycle, plus tolerance and stuck flags.
module clock_period_monitor #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned EXPECT_PERIOD = 10,
  parameter int unsigned TOLERANCE     = 1,
  parameter int unsigned TIMEOUT       = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sampleIn,
  input  logic             enable,
  output logic             measValid,
  output logic [CNT_W-1:0] measHigh,
  output logic [CNT_W-1:0] measLow,
  output logic [CNT_W:0]   measPeriod,
  output logic             periodErr,
  output logic [7:0]       errCount,
  output logic             stuck
);

  localparam int unsigned ERR_W = 8;
  localparam int unsigned PER_W = CNT_W + 1;
  localparam int unsigned CMP_W = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   p_q, p_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]       lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0]       hi_latch_q, hi_latch_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]       meas_high_q, meas_high_d;
  logic [CNT_W-1:0]       meas_low_q, meas_low_d;
  logic [PER_W-1:0]       meas_period_q, meas_period_d;
  logic                   period_err_q, period_err_d;
  logic [ERR_W-1:0]       err_count_q, err_count_d;
  logic                   stuck_q, stuck_d;

  logic                   s;
  logic [CNT_W-1:0]       hi_inc, lo_inc;
  logic [PER_W-1:0]       period_sum;
  logic signed [CMP_W-1:0] diff, mag;
  logic                   err_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Synchronizer and registered edge flags run regardless of enable.
  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], sampleIn};
    p_d    = s;
    rise_d = s & ~p_q;
    fall_d = ~s & p_q;
  end

  always_comb begin
    period_sum = {1'b0, hi_latch_q} + {1'b0, lo_cnt_q};
    diff       = $signed({1'b0, period_sum}) - $signed(CMP_W'(EXPECT_PERIOD));
    mag        = diff[CMP_W-1] ? -diff : diff;
    err_now    = mag > $signed(CMP_W'(TOLERANCE));
    hi_inc     = sat_inc(hi_cnt_q);
    lo_inc     = sat_inc(lo_cnt_q);
  end

  // Next-state and output logic; WAIT_RISE reuses hi_cnt as its idle-tick counter.
  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    lo_cnt_d      = lo_cnt_q;
    hi_latch_d    = hi_latch_q;
    meas_valid_d  = 1'b0;
    meas_high_d   = meas_high_q;
    meas_low_d    = meas_low_q;
    meas_period_d = meas_period_q;
    period_err_d  = period_err_q;
    err_count_d   = err_count_q;
    stuck_d       = stuck_q;

    if (!enable) begin
      state_d  = IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      stuck_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = WAIT_RISE;
          hi_cnt_d = '0;
          lo_cnt_d = '0;
        end
        WAIT_RISE: begin
          if (rise_q) begin
            state_d  = MEAS_HIGH;
            hi_cnt_d = CNT_W'(1);
          end else if (hi_inc >= CNT_W'(TIMEOUT)) begin
            stuck_d  = 1'b1;
            hi_cnt_d = '0;
          end else begin
            hi_cnt_d = hi_inc;
          end
        end
        MEAS_HIGH: begin
          if (fall_q) begin
            state_d    = MEAS_LOW;
            hi_latch_d = hi_cnt_q;
            lo_cnt_d   = CNT_W'(1);
          end else if (hi_inc >= CNT_W'(TIMEOUT)) begin
            state_d  = WAIT_RISE;
            stuck_d  = 1'b1;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
          end else begin
            hi_cnt_d = hi_inc;
          end
        end
        MEAS_LOW: begin
          if (rise_q) begin
            state_d       = MEAS_HIGH;
            meas_valid_d  = 1'b1;
            meas_high_d   = hi_latch_q;
            meas_low_d    = lo_cnt_q;
            meas_period_d = period_sum;
            period_err_d  = err_now;
            if (err_now && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
            hi_cnt_d      = CNT_W'(1);
          end else if (lo_inc >= CNT_W'(TIMEOUT)) begin
            state_d  = WAIT_RISE;
            stuck_d  = 1'b1;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
          end else begin
            lo_cnt_d = lo_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      p_q           <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      hi_latch_q    <= '0;
      meas_valid_q  <= 1'b0;
      meas_high_q   <= '0;
      meas_low_q    <= '0;
      meas_period_q <= '0;
      period_err_q  <= 1'b0;
      err_count_q   <= '0;
      stuck_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      p_q           <= p_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      hi_latch_q    <= hi_latch_d;
      meas_valid_q  <= meas_valid_d;
      meas_high_q   <= meas_high_d;
      meas_low_q    <= meas_low_d;
      meas_period_q <= meas_period_d;
      period_err_q  <= period_err_d;
      err_count_q   <= err_count_d;
      stuck_q       <= stuck_d;
    end
  end

  assign measValid  = meas_valid_q;
  assign measHigh   = meas_high_q;
  assign measLow    = meas_low_q;
  assign measPeriod = meas_period_q;
  assign periodErr  = period_err_q;
  assign errCount   = err_count_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Randomised bench for clock_period_monitor: a timestamp-based model of the
// measurement rules is compared against the DUT on every sampling-clock cycle.
module tb_clock_period_monitor;

  localparam int S   = 2;
  localparam int CW  = 16;
  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int TO  = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sampleIn = 1'b0;
  logic          enable = 1'b0;
  logic          measValid;
  logic [CW-1:0] measHigh, measLow;
  logic [CW:0]   measPeriod;
  logic          periodErr;
  logic [7:0]    errCount;
  logic          stuck;

  clock_period_monitor #(
    .SYNC_STAGES(S), .CNT_W(CW), .EXPECT_PERIOD(EXP), .TOLERANCE(TOL), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .sampleIn(sampleIn), .enable(enable),
    .measValid(measValid), .measHigh(measHigh), .measLow(measLow),
    .measPeriod(measPeriod), .periodErr(periodErr), .errCount(errCount),
    .stuck(stuck)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: input history plus timestamps of the last observed events.
  logic dl [0:S+1];
  int   cyc = 0;
  int   mode = 0;
  int   t_ref = 0, t_rise = 0, t_fall = 0, h_len = 0;
  bit   cmp_on = 0;
  int   e_valid = 0, e_high = 0, e_low = 0, e_period = 0, e_err = 0, e_cnt = 0, e_stuck = 0;

  task automatic model_step();
    logic d_now, d_prev, rise, fall;
    int dv;
    cyc++;
    if (reset) begin
      for (int j = 0; j <= S + 1; j++) dl[j] = 1'b0;
      mode = 0; e_valid = 0; e_high = 0; e_low = 0; e_period = 0;
      e_err = 0; e_cnt = 0; e_stuck = 0;
      cmp_on = 1;
    end else begin
      // An input change captured at edge k is acted on at edge k+S+1.
      d_now  = dl[S];
      d_prev = dl[S+1];
      rise   = d_now & ~d_prev;
      fall   = ~d_now & d_prev;
      e_valid = 0;
      if (!enable) begin
        mode = 0; e_stuck = 0;
      end else begin
        case (mode)
          0: begin mode = 1; t_ref = cyc; end
          1: if (rise) begin mode = 2; t_rise = cyc; end
             else if (cyc - t_ref >= TO) begin e_stuck = 1; t_ref = cyc; end
          2: if (fall) begin h_len = cyc - t_rise; mode = 3; t_fall = cyc; end
             else if (cyc - t_rise + 1 >= TO) begin e_stuck = 1; mode = 1; t_ref = cyc; end
          default: if (rise) begin
               e_high = h_len; e_low = cyc - t_fall; e_period = e_high + e_low;
               dv = e_period - EXP; if (dv < 0) dv = -dv;
               e_err = (dv > TOL) ? 1 : 0;
               e_valid = 1;
               if (e_err == 1 && e_cnt < 255) e_cnt++;
               mode = 2; t_rise = cyc;
             end else if (cyc - t_fall + 1 >= TO) begin e_stuck = 1; mode = 1; t_ref = cyc; end
        endcase
      end
      for (int j = S + 1; j >= 1; j--) dl[j] = dl[j-1];
      dl[0] = sampleIn;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (cmp_on) begin
        n_cmp++;
        if (measValid !== e_valid[0] || measHigh !== CW'(e_high) || measLow !== CW'(e_low) ||
            measPeriod !== (CW+1)'(e_period) || periodErr !== e_err[0] ||
            errCount !== 8'(e_cnt) || stuck !== e_stuck[0]) begin
          n_bad++;
          $display("FAIL cycle%0d outputs: got v=%b h=%0d l=%0d p=%0d err=%b cnt=%0d stuck=%b, expected v=%0d h=%0d l=%0d p=%0d err=%0d cnt=%0d stuck=%0d",
                   cyc, measValid, measHigh, measLow, measPeriod, periodErr, errCount, stuck,
                   e_valid, e_high, e_low, e_period, e_err, e_cnt, e_stuck);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic phase(input logic v, input int n);
    sampleIn = v;
    repeat (n) tick();
  endtask

  task automatic run_clk(input int h, input int l, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l;
    reset = 1'b1; enable = 1'b0; sampleIn = 1'b0;
    repeat (3) tick();
    check_lit("reset_valid", int'(measValid), 0);
    check_lit("reset_period", int'(measPeriod), 0);
    check_lit("reset_errcount", int'(errCount), 0);
    check_lit("reset_stuck", int'(stuck), 0);
    reset = 1'b0;
    repeat (2) tick();
    enable = 1'b1;

    run_clk(5, 5, 10);
    check_lit("steady_high", int'(measHigh), 5);
    check_lit("steady_low", int'(measLow), 5);
    check_lit("steady_period", int'(measPeriod), 10);
    check_lit("steady_err", int'(periodErr), 0);

    run_clk(3, 7, 5);
    check_lit("duty37_high", int'(measHigh), 3);
    check_lit("duty37_period", int'(measPeriod), 10);
    run_clk(6, 6, 5);

    phase(1'b1, 1200);
    check_lit("stuck_set", int'(stuck), 1);
    check_lit("p12_period", int'(measPeriod), 12);
    check_lit("p12_err", int'(periodErr), 1);
    check_lit("p12_errcount", int'(errCount), 5);

    run_clk(5, 5, 8);
    check_lit("stuck_hold", int'(stuck), 1);
    check_lit("resume_period", int'(measPeriod), 10);

    phase(1'b1, 5);
    phase(1'b0, 2);
    enable = 1'b0;
    phase(1'b0, 3);
    check_lit("en_drop_stuck", int'(stuck), 0);
    check_lit("en_drop_hold", int'(measHigh), 5);
    enable = 1'b1;
    run_clk(4, 6, 4);
    check_lit("re_en_high", int'(measHigh), 4);
    check_lit("re_en_low", int'(measLow), 6);

    phase(1'b1, 4);
    reset = 1'b1;
    tick();
    check_lit("midreset_high", int'(measHigh), 0);
    check_lit("midreset_errcount", int'(errCount), 0);
    reset = 1'b0;
    phase(1'b0, 6);

    run_clk(8, 8, 300);
    check_lit("sat_errcount", int'(errCount), 255);
    check_lit("sat_err", int'(periodErr), 1);
    check_lit("sat_period", int'(measPeriod), 16);

    for (int k = 0; k < 150; k++) begin
      h = int'($urandom_range(1, 12));
      l = int'($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) enable = 1'b0;
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      phase(1'b1, h);
      enable = 1'b1;
      reset = 1'b0;
      phase(1'b0, l);
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
